// File: rtl/fighter_pkg.sv
// Shared types for the fighter animation controller, sprite address decoder and collision logic.
package fighter_pkg;

    typedef enum logic [2:0] {
        ST_STAND  = 3'd0,
        ST_MOVE_L = 3'd1,
        ST_MOVE_R = 3'd2,
        ST_ATTACK = 3'd3,
        ST_DEFEND = 3'd4,
        ST_HURT   = 3'd5,
        ST_KO     = 3'd6
    } anim_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronises the vsync-rate frame clock into the Clk domain and emits a one-Clk tick
// on each rising edge of it.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic i_frame_clk,
    output logic o_tick
);

    logic r_sync1, r_sync2, r_sync3, r_tick;
    logic w_sync1_d, w_sync2_d, w_sync3_d, w_tick_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= w_sync1_d;
            r_sync2 <= w_sync2_d;
            r_sync3 <= w_sync3_d;
            r_tick  <= w_tick_d;
        end
    end

    // r_sync1/r_sync2 form the synchroniser; r_sync3 is the edge-detect history.
    always_comb begin
        w_sync1_d = i_frame_clk;
        w_sync2_d = r_sync1;
        w_sync3_d = r_sync2;
        w_tick_d  = r_sync2 & ~r_sync3;
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/fighter_anim_fsm.sv
// Per-fighter animation/action controller: state, frame and hit points advance on frame ticks,
// with registered one-Clk step, hit and block strobes.
module fighter_anim_fsm
    import fighter_pkg::*;
#(
    parameter int unsigned FW          = 8,
    parameter int unsigned HPW         = 7,
    parameter int unsigned HP_MAX      = 100,
    parameter int unsigned HURT_DMG    = 10,
    parameter int unsigned STAND_LAST  = 7,
    parameter int unsigned MOVE_LAST   = 4,
    parameter int unsigned ATK_LAST    = 8,
    parameter int unsigned DEF_LAST    = 0,
    parameter int unsigned HURT_LAST   = 3,
    parameter int unsigned KO_LAST     = 5,
    parameter int unsigned STAND_DLY   = 10,
    parameter int unsigned MOVE_DLY    = 10,
    parameter int unsigned ATK_DLY     = 3,
    parameter int unsigned DEF_DLY     = 0,
    parameter int unsigned HURT_DLY    = 2,
    parameter int unsigned KO_DLY      = 6,
    parameter int unsigned ATK_HIT_FRM = 5
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           frame_clk,
    input  logic           btn_attack,
    input  logic           btn_defend,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           hurt_in,
    output logic [2:0]     state_out,
    output logic [FW-1:0]  frame_num,
    output logic           facing_r,
    output logic           move_l,
    output logic           move_r,
    output logic           hit_pulse,
    output logic           block_pulse,
    output logic [HPW-1:0] hp,
    output logic           ko
);

    anim_state_t    r_state, w_state_d, w_req;
    logic [FW-1:0]  r_frame, w_frame_d, r_delay, w_delay_d;
    logic [FW-1:0]  w_last, w_dly, w_frame_inc;
    logic [HPW-1:0] r_hp, w_hp_d;
    logic           r_facing, w_facing_d, r_pend, w_pend_d;
    logic           r_move_l, r_move_r, r_hit, r_block;
    logic           w_move_l_d, w_move_r_d, w_hit_d, w_block_d;
    logic           w_tick, w_delay_done, w_at_last;

    frame_tick_gen u_tick (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_frame_clk (frame_clk),
        .o_tick      (w_tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_STAND;
            r_frame  <= '0;
            r_delay  <= '0;
            r_facing <= 1'b1;
            r_hp     <= HPW'(HP_MAX);
            r_pend   <= 1'b0;
            r_move_l <= 1'b0;
            r_move_r <= 1'b0;
            r_hit    <= 1'b0;
            r_block  <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_frame  <= w_frame_d;
            r_delay  <= w_delay_d;
            r_facing <= w_facing_d;
            r_hp     <= w_hp_d;
            r_pend   <= w_pend_d;
            r_move_l <= w_move_l_d;
            r_move_r <= w_move_r_d;
            r_hit    <= w_hit_d;
            r_block  <= w_block_d;
        end
    end

    always_comb begin
        w_last = '0;
        w_dly  = '0;
        case (r_state)
            ST_STAND:             begin w_last = FW'(STAND_LAST); w_dly = FW'(STAND_DLY); end
            ST_MOVE_L, ST_MOVE_R: begin w_last = FW'(MOVE_LAST);  w_dly = FW'(MOVE_DLY);  end
            ST_ATTACK:            begin w_last = FW'(ATK_LAST);   w_dly = FW'(ATK_DLY);   end
            ST_DEFEND:            begin w_last = FW'(DEF_LAST);   w_dly = FW'(DEF_DLY);   end
            ST_HURT:              begin w_last = FW'(HURT_LAST);  w_dly = FW'(HURT_DLY);  end
            ST_KO:                begin w_last = FW'(KO_LAST);    w_dly = FW'(KO_DLY);    end
            default:              begin w_last = '0;              w_dly = '0;             end
        endcase
    end

    assign w_delay_done = (r_delay >= w_dly);
    assign w_at_last    = (r_frame == w_last);
    assign w_frame_inc  = r_frame + 1'b1;

    // Left and right together cancel to STAND.
    assign w_req = btn_attack               ? ST_ATTACK :
                   btn_defend               ? ST_DEFEND :
                   (btn_left && btn_right)  ? ST_STAND  :
                   btn_left                 ? ST_MOVE_L :
                   btn_right                ? ST_MOVE_R : ST_STAND;

    always_comb begin
        w_state_d  = r_state;
        w_frame_d  = r_frame;
        w_delay_d  = r_delay;
        w_facing_d = r_facing;
        w_hp_d     = r_hp;
        w_pend_d   = r_pend | hurt_in;
        w_move_l_d = 1'b0;
        w_move_r_d = 1'b0;
        w_hit_d    = 1'b0;
        w_block_d  = 1'b0;
        if (w_tick) begin
            if (r_state == ST_KO) begin
                w_pend_d = 1'b0;
                if (!w_delay_done) begin
                    w_delay_d = r_delay + 1'b1;
                end else begin
                    w_delay_d = '0;
                    if (!w_at_last) w_frame_d = w_frame_inc;
                end
            end else if (r_pend && r_state == ST_DEFEND) begin
                w_pend_d  = hurt_in;
                w_block_d = 1'b1;
            end else if (r_pend) begin
                w_pend_d  = hurt_in;
                w_frame_d = '0;
                w_delay_d = '0;
                if (r_hp <= HPW'(HURT_DMG)) begin
                    w_hp_d    = '0;
                    w_state_d = ST_KO;
                end else begin
                    w_hp_d    = r_hp - HPW'(HURT_DMG);
                    w_state_d = ST_HURT;
                end
            end else if (r_state == ST_HURT || r_state == ST_ATTACK) begin
                if (!w_delay_done) begin
                    w_delay_d = r_delay + 1'b1;
                end else if (w_at_last) begin
                    w_state_d = ST_STAND;
                    w_frame_d = '0;
                    w_delay_d = '0;
                end else begin
                    w_delay_d = '0;
                    w_frame_d = w_frame_inc;
                    w_hit_d   = (r_state == ST_ATTACK) && (w_frame_inc == FW'(ATK_HIT_FRM));
                end
            end else begin
                if (w_req == r_state) begin
                    if (!w_delay_done) begin
                        w_delay_d = r_delay + 1'b1;
                    end else begin
                        w_delay_d = '0;
                        w_frame_d = w_at_last ? '0 : w_frame_inc;
                    end
                end else begin
                    w_state_d = w_req;
                    w_frame_d = '0;
                    w_delay_d = '0;
                    w_hit_d   = (w_req == ST_ATTACK) && (ATK_HIT_FRM == 0);
                end
                if (w_state_d == ST_MOVE_L) begin
                    w_move_l_d = 1'b1;
                    w_facing_d = 1'b0;
                end
                if (w_state_d == ST_MOVE_R) begin
                    w_move_r_d = 1'b1;
                    w_facing_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_out   = r_state;
        frame_num   = r_frame;
        facing_r    = r_facing;
        move_l      = r_move_l;
        move_r      = r_move_r;
        hit_pulse   = r_hit;
        block_pulse = r_block;
        hp          = r_hp;
        ko          = (r_state == ST_KO);
    end

endmodule

// File: tb/tb_fighter_anim_fsm.sv
// Directed self-checking bench for fighter_anim_fsm with default parameters.
module tb_fighter_anim_fsm;
    import fighter_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       btn_attack = 1'b0, btn_defend = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       hurt_in = 1'b0;
    logic [2:0] state_out;
    logic [7:0] frame_num;
    logic       facing_r, move_l, move_r, hit_pulse, block_pulse, ko;
    logic [6:0] hp;

    int unsigned n_checks = 0, n_fail = 0;
    int unsigned n_move_l = 0, n_move_r = 0, n_hit = 0, n_block = 0;
    int unsigned snap;

    fighter_anim_fsm dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .btn_attack  (btn_attack),
        .btn_defend  (btn_defend),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .hurt_in     (hurt_in),
        .state_out   (state_out),
        .frame_num   (frame_num),
        .facing_r    (facing_r),
        .move_l      (move_l),
        .move_r      (move_r),
        .hit_pulse   (hit_pulse),
        .block_pulse (block_pulse),
        .hp          (hp),
        .ko          (ko)
    );

    always #5 Clk = ~Clk;

    // Counts Clk cycles each strobe is high, so a one-cycle pulse per event adds exactly one.
    always @(posedge Clk) begin
        if (move_l)      n_move_l <= n_move_l + 1;
        if (move_r)      n_move_r <= n_move_r + 1;
        if (hit_pulse)   n_hit    <= n_hit + 1;
        if (block_pulse) n_block  <= n_block + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk) frame_clk = 1'b1;
            repeat (5) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (5) @(negedge Clk);
        end
    endtask

    task automatic pulse_hurt();
        @(negedge Clk) hurt_in = 1'b1;
        @(negedge Clk) hurt_in = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        // T1: reset values and STAND timing
        check_eq("rst_state", state_out, ST_STAND);
        check_eq("rst_frame", frame_num, 0);
        check_eq("rst_facing", facing_r, 1);
        check_eq("rst_hp", hp, 100);
        check_eq("rst_ko", ko, 0);
        do_tick(10);
        check_eq("t1_frame_after10", frame_num, 0);
        do_tick(1);
        check_eq("t1_frame_after11", frame_num, 1);
        do_tick(9);
        check_eq("t1_frame_after20", frame_num, 1);
        check_eq("t1_no_strobes", n_move_l + n_move_r + n_hit + n_block, 0);

        // T2: left then right
        btn_left = 1'b1;
        do_tick(1);
        check_eq("t2_state_movel", state_out, ST_MOVE_L);
        check_eq("t2_facing_left", facing_r, 0);
        check_eq("t2_movel_cnt", n_move_l, 1);
        btn_left = 1'b0;
        btn_right = 1'b1;
        do_tick(3);
        check_eq("t2_state_mover", state_out, ST_MOVE_R);
        check_eq("t2_mover_cnt", n_move_r, 3);
        check_eq("t2_facing_right", facing_r, 1);
        btn_right = 1'b0;
        do_tick(1);
        check_eq("t2_release_state", state_out, ST_STAND);
        check_eq("t2_release_frame", frame_num, 0);

        // T3: attack sequence, left held during attack
        btn_attack = 1'b1;
        do_tick(1);
        btn_attack = 1'b0;
        btn_left = 1'b1;
        snap = n_move_l;
        check_eq("t3_state_attack", state_out, ST_ATTACK);
        check_eq("t3_entry_frame", frame_num, 0);
        do_tick(19);
        check_eq("t3_frame4", frame_num, 4);
        check_eq("t3_no_hit_yet", n_hit, 0);
        do_tick(1);
        check_eq("t3_frame5", frame_num, 5);
        check_eq("t3_hit_once", n_hit, 1);
        do_tick(15);
        check_eq("t3_last_state", state_out, ST_ATTACK);
        check_eq("t3_last_frame", frame_num, 8);
        do_tick(1);
        check_eq("t3_exit_stand", state_out, ST_STAND);
        check_eq("t3_left_ignored", n_move_l, snap);
        check_eq("t3_hit_total", n_hit, 1);
        do_tick(1);
        check_eq("t3_then_movel", state_out, ST_MOVE_L);
        check_eq("t3_facing_left", facing_r, 0);
        btn_left = 1'b0;
        do_tick(1);

        // T4: defend absorbs a hurt
        btn_defend = 1'b1;
        do_tick(1);
        check_eq("t4_state_defend", state_out, ST_DEFEND);
        pulse_hurt();
        do_tick(1);
        check_eq("t4_block_cnt", n_block, 1);
        check_eq("t4_hp", hp, 100);
        check_eq("t4_still_defend", state_out, ST_DEFEND);
        do_tick(1);
        check_eq("t4_block_once", n_block, 1);
        btn_defend = 1'b0;
        do_tick(1);
        check_eq("t4_release", state_out, ST_STAND);

        // T5: ten undefended hurts down to KO
        for (int k = 1; k <= 10; k++) begin
            pulse_hurt();
            do_tick(1);
            check_eq($sformatf("t5_hp_%0d", k), hp, 100 - 10 * k);
            check_eq($sformatf("t5_state_%0d", k), state_out, (k < 10) ? ST_HURT : ST_KO);
        end
        check_eq("t5_ko", ko, 1);
        check_eq("t5_ko_frame0", frame_num, 0);
        btn_attack = 1'b1;
        btn_left = 1'b1;
        for (int i = 0; i < 35; i++) begin
            if (i % 5 == 0) pulse_hurt();
            do_tick(1);
            if (i == 6) check_eq("t5_ko_frame1", frame_num, 1);
        end
        check_eq("t5_ko_frame5", frame_num, 5);
        do_tick(10);
        check_eq("t5_ko_hold_frame", frame_num, 5);
        check_eq("t5_ko_hold_state", state_out, ST_KO);
        check_eq("t5_ko_hp", hp, 0);
        btn_attack = 1'b0;
        btn_left = 1'b0;
        apply_reset();
        check_eq("t5_rst_state", state_out, ST_STAND);
        check_eq("t5_rst_hp", hp, 100);
        check_eq("t5_rst_ko", ko, 0);
        check_eq("t5_rst_facing", facing_r, 1);
        check_eq("t5_rst_frame", frame_num, 0);

        // T6: hurt during attack frame 3 then Reset one Clk later
        snap = n_hit;
        btn_attack = 1'b1;
        do_tick(1);
        btn_attack = 1'b0;
        do_tick(12);
        check_eq("t6_frame3", frame_num, 3);
        @(negedge Clk) hurt_in = 1'b1;
        @(negedge Clk) begin
            hurt_in = 1'b0;
            Reset = 1'b1;
        end
        @(negedge Clk) Reset = 1'b0;
        check_eq("t6_rst_state", state_out, ST_STAND);
        check_eq("t6_rst_frame", frame_num, 0);
        do_tick(1);
        check_eq("t6_no_hurt", state_out, ST_STAND);
        check_eq("t6_hp", hp, 100);
        check_eq("t6_no_hit", n_hit, snap);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
